pipe_adder_8bit: RTL and testbench
==================================

PIPE_ADDER_8BIT -- requirements
Module: pipe_adder_8bit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports are listed in the following requirements in port order.
REQ-002 Cout  output  1  carry-out of X+Y+Cin, registered.
REQ-003 Sum  output  8  low 8 bits of X+Y+Cin, registered.
REQ-004 X  input  8  unsigned addend A.
REQ-005 Y  input  8  unsigned addend B.
REQ-006 Cin  input  1  carry-in.
REQ-007 Clk  input  1  clock; all state updates on rising edge.
REQ-008 Rst  input  1  synchronous active-high reset, appended last so existing positional instantiations (Cout, Sum, X, Y, Cin, Clk) remain valid.
REQ-009 Parameters: none; width fixed at 8.

Function
REQ-010 {Cout,Sum} SHALL equal X+Y+Cin as an unsigned 9-bit result; overflow out of bit 7 goes only to Cout.
REQ-011 Inputs SHALL be captured on rising edge E1 (input register stage).
REQ-012 The addition SHALL proceed through four 2-bit ripple slices, one per subsequent pipeline stage, bits [1:0] first, the inter-slice carry registered between stages.
REQ-013 Unprocessed upper operand bits and already-computed lower sum bits SHALL be delayed alongside the carry so every stage holds one coherent operation.
REQ-014 Result of operands captured at E1 SHALL appear on Sum/Cout immediately after rising edge E5 (5 edges total, capture edge included) and hold until E6.
REQ-015 Throughput SHALL be one new operation per clock; consecutive operations SHALL NOT interfere.
REQ-016 Input changes between edges SHALL have no effect; only values present at a rising edge are used.
REQ-017 Outputs SHALL change only on rising edges (no combinational path from inputs to outputs).
REQ-018 Boundary: 8'hFF+8'hFF+1 SHALL give Sum=8'hFF, Cout=1; 0+0+0 SHALL give Sum=0, Cout=0.

Reset
REQ-019 When Rst=1 at a rising edge, all pipeline registers, Sum and Cout SHALL become 0 on that edge.
REQ-020 Reset mid-operation SHALL discard all in-flight operations; the first valid result after reset deassertion SHALL appear 5 edges after the first capture edge with Rst=0.
REQ-021 Reset SHALL take priority over input capture on the same edge.

Structure
REQ-022 A shared package SHALL hold constants WIDTH=8, SLICE_W=2, N_SLICES=4, LATENCY=5.
REQ-023 One sub-module, pipe_add2_slice (2-bit adder with carry in/out), SHALL be instantiated once per adding stage.
REQ-024 The design SHALL be fully synchronous, single clock domain, with no latches.

Verification
REQ-025 Rst pulse, then X=6,Y=7,Cin=0 held -> Sum=13, Cout=0 after edge 5; Sum=0, Cout=0 before edge 5.
REQ-026 Back-to-back: (6,7,0),(12,24,1),(2,4,0) on consecutive edges -> Sum 13, 37, 6 on consecutive edges from edge 5, Cout=0.
REQ-027 X=128,Y=128,Cin=0 -> Sum=0, Cout=1; X=192,Y=128,Cin=1 -> Sum=65, Cout=1; X=128,Y=160,Cin=0 -> Sum=32, Cout=1.
REQ-028 X=0,Y=0,Cin=1 -> Sum=1, Cout=0; X=255,Y=255,Cin=1 -> Sum=255, Cout=1.
REQ-029 Assert Rst while 3 operations are in flight -> Sum=0, Cout=0 on the reset edge and no stale result afterwards.
REQ-030 Random stream of 1000 operations checked against a 5-edge-delayed reference model of X+Y+Cin.

Source files
------------

// File: rtl/pipe_adder_8bit_pkg.sv
// Shared constants for the pipelined 8-bit adder and its 2-bit ripple slices.
package pipe_adder_8bit_pkg;

   localparam int WIDTH    = 8;
   localparam int SLICE_W  = 2;
   localparam int N_SLICES = WIDTH / SLICE_W;
   // Edges from operand capture to result visible on Sum/Cout, capture edge included.
   localparam int LATENCY  = N_SLICES + 1;

endpackage

// File: rtl/pipe_adder_8bit_if.sv
// Operand/result bundle for the pipelined adder.
// There is no flow control: the master presents X/Y/Cin at every rising edge and each
// edge launches one operation. The slave returns the matching Sum/Cout LATENCY edges
// after capture, with no valid or ready qualification.
interface pipe_adder_8bit_if;
   import pipe_adder_8bit_pkg::*;

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (output x, output y, output cin, input sum, input cout);
   modport slave  (input x, input y, input cin, output sum, output cout);

endinterface

// File: rtl/pipe_add2_slice.sv
// Purely combinational SLICE_W-bit ripple adder with carry in and carry out.
module pipe_add2_slice
   import pipe_adder_8bit_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      logic c;
      c = ci;
      s = '0;
      for (int i = 0; i < SLICE_W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/pipe_adder_8bit.sv
// Five-edge pipelined 8-bit adder: one capture stage followed by four stages that each
// add one 2-bit slice (LSBs first). Every stage carries its pending upper operand bits
// and finished lower sum bits so the stage always describes a single operation.
// Port order is kept positional-compatible with older instantiations; Rst is appended last.
module pipe_adder_8bit
   import pipe_adder_8bit_pkg::*;
(
   output logic             Cout,
   output logic [WIDTH-1:0] Sum,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             Clk,
   input  logic             Rst
);

   // Stage 0: captured operands.
   logic [7:0] x0, y0;
   logic       c0;
   // Stage 1: bits [1:0] summed.
   logic [7:2] x1, y1;
   logic [1:0] s1;
   logic       c1;
   // Stage 2: bits [3:0] summed.
   logic [7:4] x2, y2;
   logic [3:0] s2;
   logic       c2;
   // Stage 3: bits [5:0] summed.
   logic [7:6] x3, y3;
   logic [5:0] s3;
   logic       c3;

   // Slice outputs, one per adding stage.
   logic [SLICE_W-1:0] sl0_s, sl1_s, sl2_s, sl3_s;
   logic               sl0_co, sl1_co, sl2_co, sl3_co;

   pipe_add2_slice u_slice0 (.a(x0[1:0]), .b(y0[1:0]), .ci(c0), .s(sl0_s), .co(sl0_co));
   pipe_add2_slice u_slice1 (.a(x1[3:2]), .b(y1[3:2]), .ci(c1), .s(sl1_s), .co(sl1_co));
   pipe_add2_slice u_slice2 (.a(x2[5:4]), .b(y2[5:4]), .ci(c2), .s(sl2_s), .co(sl2_co));
   pipe_add2_slice u_slice3 (.a(x3[7:6]), .b(y3[7:6]), .ci(c3), .s(sl3_s), .co(sl3_co));

   // Capture the operands presented at this edge; reset wins over capture.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         x0 <= '0;
         y0 <= '0;
         c0 <= 1'b0;
      end else begin
         x0 <= X;
         y0 <= Y;
         c0 <= Cin;
      end
   end

   // Add bits [1:0] and forward the untouched upper operand bits.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         x1 <= '0;
         y1 <= '0;
         s1 <= '0;
         c1 <= 1'b0;
      end else begin
         x1 <= x0[7:2];
         y1 <= y0[7:2];
         s1 <= sl0_s;
         c1 <= sl0_co;
      end
   end

   // Add bits [3:2] and append them to the finished low sum bits.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         x2 <= '0;
         y2 <= '0;
         s2 <= '0;
         c2 <= 1'b0;
      end else begin
         x2 <= x1[7:4];
         y2 <= y1[7:4];
         s2 <= {sl1_s, s1};
         c2 <= sl1_co;
      end
   end

   // Add bits [5:4] and append them to the finished low sum bits.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         x3 <= '0;
         y3 <= '0;
         s3 <= '0;
         c3 <= 1'b0;
      end else begin
         x3 <= x2[7:6];
         y3 <= y2[7:6];
         s3 <= {sl2_s, s2};
         c3 <= sl2_co;
      end
   end

   // Add bits [7:6] and register the complete result on the outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Sum  <= '0;
         Cout <= 1'b0;
      end else begin
         Sum  <= {sl3_s, s3};
         Cout <= sl3_co;
      end
   end

endmodule

// File: tb/tb_pipe_adder_8bit.sv
// Self-checking bench for pipe_adder_8bit: table vectors, reset corner cases and a
// random stream, all checked through an expected-result queue against a 5-edge delay.
module tb_pipe_adder_8bit;
   import pipe_adder_8bit_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipe_adder_8bit_if bus ();

   pipe_adder_8bit dut (
      .Cout (bus.cout),
      .Sum  (bus.sum),
      .X    (bus.x),
      .Y    (bus.y),
      .Cin  (bus.cin),
      .Clk  (clk),
      .Rst  (rst)
   );

   // ---------------- scoreboard ----------------
   logic [WIDTH:0] exp_q[$];
   int checks;
   int failures;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             cin;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_cout;
      string            name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got cout=%0b sum=%0d, expected cout=%0b sum=%0d",
                  name, got[WIDTH], got[WIDTH-1:0], want[WIDTH], want[WIDTH-1:0]);
      end
   endtask

   // Pipeline right after reset holds LATENCY-1 operations of 0+0+0 still to drain.
   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < LATENCY - 1; i++) exp_q.push_back('0);
   endtask

   // ---------------- driver ----------------
   // Drive one edge worth of stimulus, scramble inputs just after the edge, and compare
   // the outputs half a cycle later.
   task automatic step(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin,
                       input logic r, input logic [WIDTH:0] want, input string name);
      logic [WIDTH:0] expv;
      bus.x   = x;
      bus.y   = y;
      bus.cin = cin;
      rst     = r;
      @(posedge clk);
      #1;
      bus.x   = WIDTH'($urandom_range(0, 255));
      bus.y   = WIDTH'($urandom_range(0, 255));
      bus.cin = 1'($urandom_range(0, 1));
      if (r) begin
         model_reset();
         expv = '0;
      end else begin
         exp_q.push_back(want);
         expv = exp_q.pop_front();
      end
      @(negedge clk);
      check(name, {bus.cout, bus.sum}, expv);
   endtask

   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic cin);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
   endfunction

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- test ----------------
   initial begin
      logic [WIDTH-1:0] rx, ry;
      logic             rc;
      checks   = 0;
      failures = 0;

      vecs[0]  = '{8'd6,   8'd7,   1'b0, 8'd13,  1'b0, "b2b_6_7"};
      vecs[1]  = '{8'd12,  8'd24,  1'b1, 8'd37,  1'b0, "b2b_12_24_1"};
      vecs[2]  = '{8'd2,   8'd4,   1'b0, 8'd6,   1'b0, "b2b_2_4"};
      vecs[3]  = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, "ovf_128_128"};
      vecs[4]  = '{8'd192, 8'd128, 1'b1, 8'd65,  1'b1, "ovf_192_128_1"};
      vecs[5]  = '{8'd128, 8'd160, 1'b0, 8'd32,  1'b1, "ovf_128_160"};
      vecs[6]  = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0, "cin_only"};
      vecs[7]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, "max_max_1"};
      vecs[8]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, "zero"};
      vecs[9]  = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, "full_ripple_255_1"};
      vecs[10] = '{8'd170, 8'd85,  1'b0, 8'd255, 1'b0, "alt_170_85"};
      vecs[11] = '{8'd85,  8'd170, 1'b1, 8'd0,   1'b1, "alt_85_170_1"};

      bus.x = '0; bus.y = '0; bus.cin = 1'b0; rst = 1'b1;

      // Reset pulse: outputs must be zero on the reset edge.
      step(8'd0, 8'd0, 1'b0, 1'b1, '0, "reset_a");
      step(8'd0, 8'd0, 1'b0, 1'b1, '0, "reset_b");

      // Held operand 6+7: zero for four edges, 13 on the fifth.
      for (int i = 0; i < LATENCY; i++) step(8'd6, 8'd7, 1'b0, 1'b0, 9'd13, "held_6_7");

      // Table vectors back to back, then drain with zero operations.
      for (int i = 0; i < 12; i++)
         step(vecs[i].x, vecs[i].y, vecs[i].cin, 1'b0, {vecs[i].exp_cout, vecs[i].exp_sum},
              vecs[i].name);
      for (int i = 0; i < LATENCY - 1; i++) step(8'd0, 8'd0, 1'b0, 1'b0, '0, "drain");

      // Three operations in flight, then reset with live operands on the reset edge.
      step(8'd200, 8'd100, 1'b1, 1'b0, 9'd301, "inflight_a");
      step(8'd50,  8'd60,  1'b0, 1'b0, 9'd110, "inflight_b");
      step(8'd255, 8'd1,   1'b0, 1'b0, 9'd256, "inflight_c");
      step(8'd99,  8'd99,  1'b1, 1'b1, '0,     "reset_midflight");
      // First capture after reset: no stale results, 3+4 arrives on the fifth edge.
      step(8'd3,   8'd4,   1'b0, 1'b0, 9'd7,   "post_reset_a");
      for (int i = 0; i < LATENCY - 1; i++) step(8'd0, 8'd0, 1'b0, 1'b0, '0, "post_reset_tail");

      // Reset held for two edges with busy inputs, then a boundary operation.
      step(8'd255, 8'd255, 1'b1, 1'b1, '0, "reset_hold_a");
      step(8'd255, 8'd255, 1'b1, 1'b1, '0, "reset_hold_b");
      step(8'd255, 8'd255, 1'b1, 1'b0, 9'd511, "after_hold");
      for (int i = 0; i < LATENCY - 1; i++) step(8'd0, 8'd0, 1'b0, 1'b0, '0, "after_hold_tail");

      // Random stream against the reference sum.
      for (int i = 0; i < 1000; i++) begin
         rx = WIDTH'($urandom_range(0, 255));
         ry = WIDTH'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         step(rx, ry, rc, 1'b0, ref_add(rx, ry, rc), "random");
      end
      for (int i = 0; i < LATENCY - 1; i++) step(8'd0, 8'd0, 1'b0, 1'b0, '0, "random_drain");

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
